// File: rtl/shell_pkg.sv
// Shared types and constants for the shell command decoder: FSM states, TX string
// selectors, ASCII bytes and the string ROM lookup helpers.
package shell_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHaveCmd,
    StFire,
    StWaitShell,
    StSend,
    StEcho
  } state_e;

  typedef enum logic [1:0] {
    StrOk,
    StrNak,
    StrCrlf,
    StrByte
  } str_sel_e;

  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;
  localparam logic [7:0] AsciiO     = 8'h4F;
  localparam logic [7:0] AsciiK     = 8'h4B;
  localparam logic [7:0] AsciiQmark = 8'h3F;

  localparam int unsigned AckLen = 4;
  localparam int unsigned NakLen = 3;

  // Index of the final byte of each string.
  function automatic logic [1:0] str_last(str_sel_e sel);
    logic [1:0] last;
    last = 2'd0;
    case (sel)
      StrOk:   last = 2'(AckLen - 1);
      StrNak:  last = 2'(NakLen - 1);
      StrCrlf: last = 2'd1;
      default: last = 2'd0;
    endcase
    return last;
  endfunction

  function automatic logic [7:0] str_byte(str_sel_e sel, logic [1:0] idx, logic [7:0] echo_byte);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      StrOk: begin
        case (idx)
          2'd0:    b = AsciiO;
          2'd1:    b = AsciiK;
          2'd2:    b = AsciiCr;
          default: b = AsciiLf;
        endcase
      end
      StrNak: begin
        case (idx)
          2'd0:    b = AsciiQmark;
          2'd1:    b = AsciiCr;
          default: b = AsciiLf;
        endcase
      end
      StrCrlf: b = (idx == 2'd0) ? AsciiCr : AsciiLf;
      default: b = echo_byte;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/shell_cmd_decoder_if.sv
// UART-side byte streams of the shell command decoder (RX into the decoder, TX out of it).
interface shell_cmd_decoder_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  // master: the UART/host side; slave: the decoder.
  modport master (output rx_valid, rx_data, tx_ready, input rx_ready, tx_valid, tx_data);
  modport slave (input rx_valid, rx_data, tx_ready, output rx_ready, tx_valid, tx_data);
endinterface

// File: rtl/shell_tx_string.sv
// String ROM plus index/length sequencer driving a valid/ready TX byte stream.
module shell_tx_string
  import shell_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  str_sel_e   sel,
  input  logic [7:0] echo_byte,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       done
);

  str_sel_e   sel_q;
  logic [7:0] byte_q;
  logic [1:0] idx_q;
  logic [1:0] last_q;
  logic       valid_q;
  logic [7:0] data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q   <= StrOk;
      byte_q  <= 8'h00;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else if (start) begin
      sel_q   <= sel;
      byte_q  <= echo_byte;
      idx_q   <= 2'd0;
      last_q  <= str_last(sel);
      valid_q <= 1'b1;
      data_q  <= str_byte(sel, 2'd0, echo_byte);
    end else if (valid_q && tx_ready) begin
      if (idx_q == last_q) begin
        valid_q <= 1'b0;
        data_q  <= 8'h00;
      end else begin
        idx_q  <= idx_q + 2'd1;
        data_q <= str_byte(sel_q, idx_q + 2'd1, byte_q);
      end
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign done     = valid_q && tx_ready && (idx_q == last_q);

endmodule

// File: rtl/shell_cmd_decoder.sv
// Shell command decoder: turns single-char RX commands into mode switch/restore pulses and
// ACK/NAK strings; sniffs for an escape burst in app mode. Echo enabled by SHELL_ECHO_EN.
module shell_cmd_decoder
  import shell_pkg::*;
#(
  parameter logic [7:0]  CMD_RUN   = 8'h72,
  parameter logic [7:0]  CMD_SHELL = 8'h73,
  parameter logic [7:0]  ESC_CHAR  = 8'h03,
  parameter int unsigned ESC_COUNT = 3
) (
  input  logic                clk,
  input  logic                resetn,
  shell_cmd_decoder_if.slave  bus,
  input  logic                app_mode,
  output logic                shell_mode_switch,
  output logic                shell_mode_restore,
  output logic                cmd_error
);

  state_e     state_q;
  logic [7:0] cmd_q;
  logic       malformed_q;
  logic [3:0] esc_cnt_q;
  logic       rx_ready_q;
  logic       switch_q;
  logic       restore_q;
  logic       error_q;
`ifdef SHELL_ECHO_EN
  logic       chain_q;
  str_sel_e   pend_sel_q;
`endif

  logic       rx_fire;
  logic       rx_term;
  logic       cmd_ok;
  logic       str_start;
  str_sel_e   str_sel;
  logic [7:0] echo_byte;
  logic       tx_done;
  logic       send_last;
  logic       tx_valid_w;
  logic [7:0] tx_data_w;

  assign rx_fire = bus.rx_valid && rx_ready_q;
  assign rx_term = (bus.rx_data == AsciiCr) || (bus.rx_data == AsciiLf);
  assign cmd_ok  = !malformed_q && ((cmd_q == CMD_RUN) || (cmd_q == CMD_SHELL));

`ifdef SHELL_ECHO_EN
  // The CR/LF echo precedes the ACK/NAK, so SEND only ends after the chained string.
  assign send_last = tx_done && !chain_q;
`else
  assign send_last = tx_done;
`endif

  always_comb begin
    str_start = 1'b0;
    str_sel   = StrOk;
    echo_byte = 8'h00;
    case (state_q)
      StFire: begin
        str_start = 1'b1;
`ifdef SHELL_ECHO_EN
        str_sel = StrCrlf;
`else
        str_sel = cmd_ok ? StrOk : StrNak;
`endif
      end
      StWaitShell: str_start = !app_mode;
`ifdef SHELL_ECHO_EN
      StIdle, StHaveCmd: begin
        if (rx_fire && !rx_term && (state_q == StHaveCmd || !app_mode)) begin
          str_start = 1'b1;
          str_sel   = StrByte;
          echo_byte = bus.rx_data;
        end
      end
      StSend: begin
        if (tx_done && chain_q) begin
          str_start = 1'b1;
          str_sel   = pend_sel_q;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cmd_q       <= 8'h00;
      malformed_q <= 1'b0;
      esc_cnt_q   <= 4'd0;
      rx_ready_q  <= 1'b0;
      switch_q    <= 1'b0;
      restore_q   <= 1'b0;
      error_q     <= 1'b0;
`ifdef SHELL_ECHO_EN
      chain_q     <= 1'b0;
      pend_sel_q  <= StrOk;
`endif
    end else begin
      switch_q  <= 1'b0;
      restore_q <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          rx_ready_q <= 1'b1;
          if (app_mode) begin
            if (rx_fire) begin
              if (bus.rx_data == ESC_CHAR) begin
                if (esc_cnt_q + 4'd1 == 4'(ESC_COUNT)) begin
                  restore_q  <= 1'b1;
                  esc_cnt_q  <= 4'd0;
                  rx_ready_q <= 1'b0;
                  state_q    <= StWaitShell;
                end else begin
                  esc_cnt_q <= esc_cnt_q + 4'd1;
                end
              end else begin
                esc_cnt_q <= 4'd0;
              end
            end
          end else begin
            esc_cnt_q <= 4'd0;
            if (rx_fire && !rx_term) begin
              cmd_q <= bus.rx_data;
`ifdef SHELL_ECHO_EN
              rx_ready_q <= 1'b0;
              state_q    <= StEcho;
`else
              state_q    <= StHaveCmd;
`endif
            end
          end
        end
        StHaveCmd: begin
          if (rx_fire) begin
            if (rx_term) begin
              rx_ready_q <= 1'b0;
              state_q    <= StFire;
              if (cmd_ok && cmd_q == CMD_RUN) begin
                switch_q <= 1'b1;
              end else if (cmd_ok) begin
                restore_q <= 1'b1;
              end else begin
                error_q <= 1'b1;
              end
            end else begin
              malformed_q <= 1'b1;
`ifdef SHELL_ECHO_EN
              rx_ready_q  <= 1'b0;
              state_q     <= StEcho;
`endif
            end
          end
        end
        StFire: begin
          state_q <= StSend;
`ifdef SHELL_ECHO_EN
          chain_q    <= 1'b1;
          pend_sel_q <= cmd_ok ? StrOk : StrNak;
`endif
        end
        StSend: begin
`ifdef SHELL_ECHO_EN
          if (tx_done) chain_q <= 1'b0;
`endif
          if (send_last) begin
            cmd_q       <= 8'h00;
            malformed_q <= 1'b0;
            rx_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StWaitShell: begin
          if (!app_mode) state_q <= StSend;
        end
`ifdef SHELL_ECHO_EN
        StEcho: begin
          if (tx_done) begin
            rx_ready_q <= 1'b1;
            state_q    <= StHaveCmd;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  shell_tx_string u_tx_string (
    .clk       (clk),
    .resetn    (resetn),
    .start     (str_start),
    .sel       (str_sel),
    .echo_byte (echo_byte),
    .tx_ready  (bus.tx_ready),
    .tx_valid  (tx_valid_w),
    .tx_data   (tx_data_w),
    .done      (tx_done)
  );

  assign bus.rx_ready       = rx_ready_q;
  assign bus.tx_valid       = tx_valid_w;
  assign bus.tx_data        = tx_data_w;
  assign shell_mode_switch  = switch_q;
  assign shell_mode_restore = restore_q;
  assign cmd_error          = error_q;

endmodule

// File: tb/tb_shell_cmd_decoder.sv
// Bench for shell_cmd_decoder: string-level command model checked every cycle, plus
// directed scenarios with literal expectations. Honours SHELL_ECHO_EN like the design.
module tb_shell_cmd_decoder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic app_mode = 1'b0;
  logic sw, rs, err;

  shell_cmd_decoder_if bus ();

  shell_cmd_decoder dut (
    .clk                (clk),
    .resetn             (resetn),
    .bus                (bus),
    .app_mode           (app_mode),
    .shell_mode_switch  (sw),
    .shell_mode_restore (rs),
    .cmd_error          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: pending command text, expected TX bytes, expected pulses for next cycle.
  logic [7:0] exp_q[$];
  logic [7:0] cmd_buf[$];
  logic [7:0] tx_log[$];
  int esc_n = 0;
  logic exp_sw = 0, exp_rs = 0, exp_err = 0;
  int n_sw = 0, n_rs = 0, n_err = 0;
  int term_cyc = 0, pulse_cyc = 0;
  bit quiet = 0;
  bit slow = 0;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      exp_q.delete();
      cmd_buf.delete();
      esc_n = 0;
      exp_sw = 0;
      exp_rs = 0;
      exp_err = 0;
    end else begin
      chk("switch_pulse", sw, exp_sw);
      chk("restore_pulse", rs, exp_rs);
      chk("error_pulse", err, exp_err);
      if (sw) begin n_sw++; pulse_cyc = cyc; end
      if (rs) begin n_rs++; pulse_cyc = cyc; end
      if (err) begin n_err++; pulse_cyc = cyc; end
      if (quiet) chk("tx_quiet_in_app", bus.tx_valid, 0);
      if (bus.tx_valid && bus.tx_ready) begin
        tx_log.push_back(bus.tx_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h expected no byte (cycle %0d)", bus.tx_data, cyc);
        end else begin
          chk("tx_byte", bus.tx_data, exp_q.pop_front());
        end
      end
      exp_sw = 0;
      exp_rs = 0;
      exp_err = 0;
      if (!app_mode) esc_n = 0;
      if (bus.rx_valid && bus.rx_ready) begin
        if (app_mode) begin
          if (bus.rx_data == 8'h03) begin
            esc_n++;
            if (esc_n == 3) begin
              esc_n = 0;
              exp_rs = 1;
              exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
              exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
            end
          end else begin
            esc_n = 0;
          end
        end else if (bus.rx_data == 8'h0D || bus.rx_data == 8'h0A) begin
          if (cmd_buf.size() != 0) begin
            term_cyc = cyc;
`ifdef SHELL_ECHO_EN
            exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
`endif
            if (cmd_buf.size() == 1 && (cmd_buf[0] == 8'h72 || cmd_buf[0] == 8'h73)) begin
              if (cmd_buf[0] == 8'h72) exp_sw = 1;
              else exp_rs = 1;
              exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
              exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
            end else begin
              exp_err = 1;
              exp_q.push_back(8'h3F); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
            end
            cmd_buf.delete();
          end
        end else begin
`ifdef SHELL_ECHO_EN
          exp_q.push_back(bus.rx_data);
`endif
          cmd_buf.push_back(bus.rx_data);
        end
      end
    end
  end

  // TX sink: always ready, or ready one cycle in three.
  int rc = 0;
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      bus.tx_ready = slow ? (rc % 3 == 0) : 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.rx_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout: byte %0h never accepted, expected rx_ready", b);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.tx_valid && bus.rx_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, tx_log.size(), e.size());
    for (int i = 0; i < e.size() && i < tx_log.size(); i++) chk(name, tx_log[i], e[i]);
  endtask

  logic [7:0] exp_t1[$];
  logic [7:0] exp_ok[$];
  int base_sw, base_rs, base_err;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    exp_ok = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
`ifdef SHELL_ECHO_EN
    exp_t1 = '{8'h72, 8'h0D, 8'h0A, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
`else
    exp_t1 = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
`endif

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_ready", bus.rx_ready, 0);
    chk("reset_tx_valid", bus.tx_valid, 0);
    chk("reset_tx_data", bus.tx_data, 0);
    chk("reset_switch", sw, 0);
    chk("reset_restore", rs, 0);
    chk("reset_error", err, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 'r' CR with a slow sink
    tx_log.delete();
    slow = 1;
    send_byte(8'h72);
    send_byte(8'h0D);
    drain();
    slow = 0;
    chk("t1_switch_count", n_sw, 1);
    chk("t1_pulse_latency", pulse_cyc - term_cyc, 1);
    chk_log("t1_tx", exp_t1);

    // 's' LF
    base_sw = n_sw; base_rs = n_rs;
    send_byte(8'h73);
    send_byte(8'h0A);
    drain();
    chk("t2_restore_count", n_rs - base_rs, 1);
    chk("t2_switch_count", n_sw - base_sw, 0);

    // Unknown and malformed commands, plus a bare terminator that must be ignored
    base_sw = n_sw; base_rs = n_rs; base_err = n_err;
    send_byte(8'h0D);
    send_byte(8'h78);
    send_byte(8'h0D);
    drain();
    send_byte(8'h72);
    send_byte(8'h72);
    send_byte(8'h0D);
    drain();
    chk("t3_error_count", n_err - base_err, 2);
    chk("t3_no_mode_pulse", (n_sw - base_sw) + (n_rs - base_rs), 0);

    // Escape burst in app mode
    tx_log.delete();
    app_mode = 1'b1;
    quiet = 1;
    base_rs = n_rs;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h03);
    send_byte(8'h03);
    send_byte(8'h41);
    send_byte(8'h03);
    send_byte(8'h03);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_early_restore", n_rs - base_rs, 0);
    send_byte(8'h03);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_restore_count", n_rs - base_rs, 1);
    chk("t4_no_tx_in_app", tx_log.size(), 0);
    quiet = 0;
    app_mode = 1'b0;
    drain();
    chk_log("t4_tx", exp_ok);

    // Reset during the second byte of "OK\r\n"
    tx_log.delete();
    send_byte(8'h72);
    send_byte(8'h0D);
    begin
      bit ok;
      ok = 0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (tx_log.size() >= exp_t1.size() - 3) begin ok = 1; break; end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL t5_first_byte_timeout: log %0d bytes, expected %0d", tx_log.size(),
                 exp_t1.size() - 3);
      end
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_tx_valid_after_reset", bus.tx_valid, 0);
    chk("t5_rx_ready_in_reset", bus.rx_ready, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle_rx_ready", bus.rx_ready, 1);
    chk("t5_idle_tx_valid", bus.tx_valid, 0);
    tx_log.delete();
    base_sw = n_sw;
    @(posedge clk);
    #1;
    send_byte(8'h72);
    send_byte(8'h0D);
    drain();
    chk("t5_switch_count", n_sw - base_sw, 1);
    chk_log("t5_tx", exp_t1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
